step_accumulator: RTL

STEP_ACCUMULATOR -- requirements
Module: step_accumulator

---
 rtl/step_accum_pkg.sv | 18 +
 rtl/step_accumulator_if.sv | 33 +++
 rtl/step_prescaler.sv | 34 +++
 rtl/step_accumulator.sv | 81 ++++++++
 4 files changed

// File: rtl/step_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : step_accum_pkg
// Description : Shared overflow-mode constants for the step accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package step_accum_pkg;

    localparam int ACC_MODE_WRAP = 0;
    localparam int ACC_MODE_SAT  = 1;

    // Prescaler counter width, never narrower than one bit.
    function automatic int prescale_cnt_w(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : step_accumulator_if
// Description : Control/data bundle between a step_accumulator and its user.
// Revision    : 1.0 - initial release
// ============================================================================
interface step_accumulator_if
    import step_accum_pkg::*;
#(
    parameter int WIDTH = 11
);
    logic             en;
    logic             dir;
    logic [WIDTH-1:0] m;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] s;
    logic             tick;
    logic             wrap_p;
    logic             ovf;

    modport master (
        output en, dir, m, load, load_val, clr_ovf,
        input  s, tick, wrap_p, ovf
    );

    modport slave (
        input  en, dir, m, load, load_val, clr_ovf,
        output s, tick, wrap_p, ovf
    );
endinterface
`default_nettype wire

// File: rtl/step_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : step_prescaler
// Description : Enable-gated modulo-PRESCALE counter with combinational tick.
// Revision    : 1.0 - initial release
// ============================================================================
module step_prescaler
    import step_accum_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int                 c_CNT_W = prescale_cnt_w(PRESCALE);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(PRESCALE - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_last;

    assign w_last = (r_cnt == c_LAST);
    assign tick   = en & w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + c_CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/step_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : step_accumulator
// Description : Prescaled up/down step accumulator with wrap or saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module step_accumulator
    import step_accum_pkg::*;
#(
    parameter int WIDTH    = 11,
    parameter int PRESCALE = 1,
    parameter int MODE     = ACC_MODE_WRAP
) (
    input  logic               clk,
    input  logic               rst,
    step_accumulator_if.slave  bus
);
    logic             w_tick;
    logic [WIDTH:0]   w_ext;
    logic             w_event;
    logic             w_acc_evt;
    logic [WIDTH-1:0] w_next;

    logic [WIDTH-1:0] r_s;
    logic             r_tick;
    logic             r_wrap;
    logic             r_ovf;

    step_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .tick (w_tick)
    );

    // The extra top bit is the carry on add and the borrow on subtract.
    assign w_ext = bus.dir ? ({1'b0, r_s} - {1'b0, bus.m})
                           : ({1'b0, r_s} + {1'b0, bus.m});
    assign w_event   = w_ext[WIDTH];
    assign w_acc_evt = w_tick & ~bus.load & w_event;

    generate
        if (MODE == ACC_MODE_SAT) begin : g_sat
            assign w_next = !w_event ? w_ext[WIDTH-1:0]
                          : (bus.dir ? '0 : '1);
        end else begin : g_wrap
            assign w_next = w_ext[WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_tick <= w_tick;
            r_wrap <= w_acc_evt;
            if (bus.load) begin
                r_s <= bus.load_val;
            end else if (w_tick) begin
                r_s <= w_next;
            end
            // A fresh event outranks a simultaneous clear.
            if (w_acc_evt) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.s      = r_s;
    assign bus.tick   = r_tick;
    assign bus.wrap_p = r_wrap;
    assign bus.ovf    = r_ovf;
endmodule
`default_nettype wire
